decode_stage: RTL and testbench

//  Parametrised RV64I/M integer decode stage between fetch and register file/ALU.

---
 rtl/decode_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV64I/M (or RV32I/M) integer decode with a 2-entry skid buffer.
// Define DECODE_MUL_EN to decode the M extension; otherwise those encodings are illegal.
module decode_stage #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INS_WIDTH-1:0]      in_ins,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_alu_control,
  output logic [4:0]                out_addressA,
  output logic [4:0]                out_addressB,
  output logic [4:0]                out_addressC,
  output logic [BUS_DATA_WIDTH-1:0] out_imm,
  output logic                      out_muxB_control,
  output logic                      out_word,
  output logic                      out_illegal
);
`ifdef DECODE_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  localparam bit RV64 = BUS_DATA_WIDTH == 64;
  typedef struct packed {
    logic [5:0]                alu;
    logic [4:0]                a, b, c;
    logic [BUS_DATA_WIDTH-1:0] imm;
    logic                      muxb, word, ill;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic [5:0] w_alu;
  logic       w_ok, w_imm_use, w_word, w_acc, w_drn;
  bundle_t    w_dec, r_main, r_skid;
  state_t     r_state;
  assign w_op = in_ins[6:0];
  assign w_f3 = in_ins[14:12];
  assign w_f7 = in_ins[31:25];
  always_comb begin
    w_alu = '0;
    w_ok = 1'b0;
    w_imm_use = 1'b0;
    w_word = 1'b0;
    case (w_op)
      7'b0010011: begin
        w_imm_use = 1'b1;
        w_ok = 1'b1;
        case (w_f3)
          3'b000: w_alu = (in_ins[31:7] == '0) ? 6'd0 : 6'd1;
          3'b001: w_alu = 6'd7;
          3'b010: w_alu = 6'd2;
          3'b011: w_alu = 6'd3;
          3'b100: w_alu = 6'd4;
          3'b110: w_alu = 6'd5;
          3'b111: w_alu = 6'd6;
          default: begin
            // RV64 shamt is 6 bits, so only ins[31:26] qualifies the shift type
            w_ok = RV64 ? (in_ins[31:26] == 6'b000000 || in_ins[31:26] == 6'b010000)
                        : (w_f7 == 7'h00 || w_f7 == 7'h20);
            w_alu = in_ins[30] ? 6'd9 : 6'd8;
          end
        endcase
      end
      7'b0110011: begin
        case (w_f7)
          7'h00: begin
            w_ok = 1'b1;
            case (w_f3)
              3'd0: w_alu = 6'd12;
              3'd1: w_alu = 6'd14;
              3'd2: w_alu = 6'd15;
              3'd3: w_alu = 6'd16;
              3'd4: w_alu = 6'd17;
              3'd5: w_alu = 6'd18;
              3'd6: w_alu = 6'd20;
              default: w_alu = 6'd21;
            endcase
          end
          7'h20: begin
            w_ok = w_f3 == 3'd0 || w_f3 == 3'd5;
            w_alu = w_f3 == 3'd0 ? 6'd13 : 6'd19;
          end
          7'h01: begin
            w_ok = MUL;
            w_alu = 6'd31 + {3'b000, w_f3};
          end
          default: ;
        endcase
      end
      7'b0011011: begin
        w_imm_use = 1'b1;
        w_word = 1'b1;
        w_ok = RV64 && (w_f3 == 3'd0 || (w_f3 == 3'd1 && w_f7 == 7'h00) ||
                        (w_f3 == 3'd5 && (w_f7 == 7'h00 || w_f7 == 7'h20)));
        w_alu = w_f3 == 3'd0 ? 6'd22 : w_f3 == 3'd1 ? 6'd23 : in_ins[30] ? 6'd25 : 6'd24;
      end
      7'b0111011: begin
        w_word = 1'b1;
        case ({w_f7, w_f3})
          {7'h00, 3'd0}: w_alu = 6'd26;
          {7'h20, 3'd0}: w_alu = 6'd27;
          {7'h00, 3'd1}: w_alu = 6'd28;
          {7'h00, 3'd5}: w_alu = 6'd29;
          {7'h20, 3'd5}: w_alu = 6'd30;
          {7'h01, 3'd0}: w_alu = MUL ? 6'd39 : 6'd0;
          {7'h01, 3'd4}: w_alu = MUL ? 6'd40 : 6'd0;
          {7'h01, 3'd5}: w_alu = MUL ? 6'd41 : 6'd0;
          {7'h01, 3'd6}: w_alu = MUL ? 6'd42 : 6'd0;
          {7'h01, 3'd7}: w_alu = MUL ? 6'd43 : 6'd0;
          default: w_alu = 6'd0;
        endcase
        w_ok = RV64 && w_alu != 6'd0;
      end
      default: ;
    endcase
  end
  // Illegal encodings yield a clean bundle so no stale control leaks through
  assign w_dec = w_ok ? '{alu: w_alu, a: in_ins[19:15], b: w_imm_use ? 5'd0 : in_ins[24:20],
                          c: in_ins[11:7],
                          imm: w_imm_use ? {{(BUS_DATA_WIDTH-12){in_ins[31]}}, in_ins[31:20]} : '0,
                          muxb: w_imm_use, word: w_word, ill: 1'b0}
                      : '{alu: 6'd0, a: 5'd0, b: 5'd0, c: 5'd0, imm: '0, muxb: 1'b0, word: 1'b0, ill: 1'b1};
  assign in_ready = r_state != TWO;
  assign out_valid = r_state != EMPTY;
  assign w_acc = in_valid & in_ready;
  assign w_drn = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) begin
          r_main <= w_dec;
          r_state <= ONE;
        end
        ONE: if (w_acc && w_drn) r_main <= w_dec;
          else if (w_acc) begin
            r_skid <= w_dec;
            r_state <= TWO;
          end else if (w_drn) r_state <= EMPTY;
        default: if (w_drn) begin
          r_main <= r_skid;
          r_state <= ONE;
        end
      endcase
    end
  end
  assign out_alu_control = r_main.alu;
  assign out_addressA = r_main.a;
  assign out_addressB = r_main.b;
  assign out_addressC = r_main.c;
  assign out_imm = r_main.imm;
  assign out_muxB_control = r_main.muxb;
  assign out_word = r_main.word;
  assign out_illegal = r_main.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage against a table-driven decode model.
module tb_decode_stage;
  localparam int W = 64;
`ifdef DECODE_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ins = '0;
  logic in_ready, out_valid, out_muxB_control, out_word, out_illegal;
  logic [5:0] out_alu_control;
  logic [4:0] out_addressA, out_addressB, out_addressC;
  logic [W-1:0] out_imm;
  decode_stage #(.BUS_DATA_WIDTH(W), .INS_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
    .out_addressA(out_addressA), .out_addressB(out_addressB), .out_addressC(out_addressC),
    .out_imm(out_imm), .out_muxB_control(out_muxB_control), .out_word(out_word),
    .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [5:0] alu;
    logic [4:0] a, b, c;
    logic [W-1:0] imm;
    logic muxb, word, ill;
  } exp_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7, mask;
    logic [5:0] code;
  } enc_t;
  enc_t tbl[$];
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  function automatic void add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [6:0] mask, input logic [5:0] code);
    enc_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.mask = mask; e.code = code;
    tbl.push_back(e);
  endfunction
  function automatic void build_table();
    add(7'h13, 3'd0, 7'h00, 7'h00, 6'd1);
    add(7'h13, 3'd2, 7'h00, 7'h00, 6'd2);
    add(7'h13, 3'd3, 7'h00, 7'h00, 6'd3);
    add(7'h13, 3'd4, 7'h00, 7'h00, 6'd4);
    add(7'h13, 3'd6, 7'h00, 7'h00, 6'd5);
    add(7'h13, 3'd7, 7'h00, 7'h00, 6'd6);
    add(7'h13, 3'd1, 7'h00, 7'h00, 6'd7);
    add(7'h13, 3'd5, 7'h00, 7'h7E, 6'd8);
    add(7'h13, 3'd5, 7'h20, 7'h7E, 6'd9);
    add(7'h33, 3'd0, 7'h00, 7'h7F, 6'd12);
    add(7'h33, 3'd0, 7'h20, 7'h7F, 6'd13);
    add(7'h33, 3'd1, 7'h00, 7'h7F, 6'd14);
    add(7'h33, 3'd2, 7'h00, 7'h7F, 6'd15);
    add(7'h33, 3'd3, 7'h00, 7'h7F, 6'd16);
    add(7'h33, 3'd4, 7'h00, 7'h7F, 6'd17);
    add(7'h33, 3'd5, 7'h00, 7'h7F, 6'd18);
    add(7'h33, 3'd5, 7'h20, 7'h7F, 6'd19);
    add(7'h33, 3'd6, 7'h00, 7'h7F, 6'd20);
    add(7'h33, 3'd7, 7'h00, 7'h7F, 6'd21);
    add(7'h1B, 3'd0, 7'h00, 7'h00, 6'd22);
    add(7'h1B, 3'd1, 7'h00, 7'h7F, 6'd23);
    add(7'h1B, 3'd5, 7'h00, 7'h7F, 6'd24);
    add(7'h1B, 3'd5, 7'h20, 7'h7F, 6'd25);
    add(7'h3B, 3'd0, 7'h00, 7'h7F, 6'd26);
    add(7'h3B, 3'd0, 7'h20, 7'h7F, 6'd27);
    add(7'h3B, 3'd1, 7'h00, 7'h7F, 6'd28);
    add(7'h3B, 3'd5, 7'h00, 7'h7F, 6'd29);
    add(7'h3B, 3'd5, 7'h20, 7'h7F, 6'd30);
    if (MUL) begin
      add(7'h33, 3'd0, 7'h01, 7'h7F, 6'd31);
      add(7'h33, 3'd1, 7'h01, 7'h7F, 6'd32);
      add(7'h33, 3'd2, 7'h01, 7'h7F, 6'd33);
      add(7'h33, 3'd3, 7'h01, 7'h7F, 6'd34);
      add(7'h33, 3'd4, 7'h01, 7'h7F, 6'd35);
      add(7'h33, 3'd5, 7'h01, 7'h7F, 6'd36);
      add(7'h33, 3'd6, 7'h01, 7'h7F, 6'd37);
      add(7'h33, 3'd7, 7'h01, 7'h7F, 6'd38);
      add(7'h3B, 3'd0, 7'h01, 7'h7F, 6'd39);
      add(7'h3B, 3'd4, 7'h01, 7'h7F, 6'd40);
      add(7'h3B, 3'd5, 7'h01, 7'h7F, 6'd41);
      add(7'h3B, 3'd6, 7'h01, 7'h7F, 6'd42);
      add(7'h3B, 3'd7, 7'h01, 7'h7F, 6'd43);
    end
  endfunction
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    bit immop;
    e = '0;
    e.ill = 1'b1;
    immop = ins[6:0] == 7'h13 || ins[6:0] == 7'h1B;
    foreach (tbl[i])
      if (tbl[i].op == ins[6:0] && tbl[i].f3 == ins[14:12] && ((ins[31:25] ^ tbl[i].f7) & tbl[i].mask) == 7'h00) begin
        e.ill = 1'b0;
        e.alu = tbl[i].code;
        e.a = ins[19:15];
        e.b = immop ? 5'd0 : ins[24:20];
        e.c = ins[11:7];
        e.imm = immop ? {{(W-12){ins[31]}}, ins[31:20]} : '0;
        e.muxb = immop;
        e.word = ins[6:0] == 7'h1B || ins[6:0] == 7'h3B;
      end
    if (ins == 32'h0000_0013) e.alu = 6'd0;
    return e;
  endfunction
  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endfunction
  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [6:0] op, f7;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: op = 7'h13;
      1: op = 7'h33;
      2: op = 7'h1B;
      3: op = 7'h3B;
      default: op = r[6:0];
    endcase
    case ($urandom_range(0, 4))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      3: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    if ($urandom_range(0, 20) == 0) return 32'h0000_0013;
    return {f7, r[24:7], op};
  endfunction
  always @(negedge clk)
    if (reset_n && in_valid && in_ready) sb.push_back(model(in_ins));
  always @(negedge clk)
    if (reset_n && out_valid && out_ready) begin : mon
      exp_t got, e;
      got = '{alu: out_alu_control, a: out_addressA, b: out_addressB, c: out_addressC, imm: out_imm,
              muxb: out_muxB_control, word: out_word, ill: out_illegal};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got alu=%0d ill=%0b with nothing pending", got.alu, got.ill);
      end else begin
        e = sb.pop_front();
        if (e.ill ? (got.alu !== 6'd0 || got.ill !== 1'b1) : (got !== e)) begin
          miscompares++;
          $display("FAIL bundle got alu=%0d a=%0d b=%0d c=%0d imm=%0h mux=%0b w=%0b ill=%0b expected alu=%0d a=%0d b=%0d c=%0d imm=%0h mux=%0b w=%0b ill=%0b",
                   got.alu, got.a, got.b, got.c, got.imm, got.muxb, got.word, got.ill,
                   e.alu, e.a, e.b, e.c, e.imm, e.muxb, e.word, e.ill);
        end
      end
    end
  task automatic send(input logic [31:0] ins);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_ins = ins;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask
  initial begin
    build_table();
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_ins = 32'h00A2_8293;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_alu", 64'(out_alu_control), 64'd0);
    chk("reset_imm", out_imm, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00A2_8293);
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    send(32'hFFF2_C313);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h4062_8333);
    send(32'h0062_F3B3);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(32'h0262_82B3);
    send(32'h0000_007F);
    send(32'h0000_0013);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h00A2_8293);
    send(32'h0000_007F);
    @(negedge clk);
    chk("two_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_ins = gen();
      out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
